main: RTL and testbench

Top-level controller for a three-colour signal lamp (red/yellow/green) on a 50 MHz board. It debounces two push-buttons and runs one of three lamp modes: automatic red→green→yellow cycling, flashing yellow, or off. It drives four active-high LEDs directly and is the top of the ThreeColorLight design.

---
 rtl/main.sv | 174 +++++++++++++++++
 tb/tb_main.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/main.sv
// Three-colour lamp controller: debounced MODE/SKIP keys select AUTO cycling, flashing yellow or off.
// LED is registered one cycle after mode/phase; `HEARTBEAT_EN adds a toggling LED[3].
module main #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
  parameter int unsigned RED_CYC        = 250_000_000,
  parameter int unsigned GREEN_CYC      = 250_000_000,
  parameter int unsigned YELLOW_CYC     = 100_000_000,
  parameter int unsigned FLASH_HALF_CYC = 25_000_000
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key,
  output logic [3:0] LED
);

  if (CLK_HZ == 0 || DEBOUNCE_CYC == 0 || RED_CYC == 0 || GREEN_CYC == 0 ||
      YELLOW_CYC == 0 || FLASH_HALF_CYC == 0) begin : g_param_check
    $error("main: all timing parameters must be at least 1");
  end

  localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] RED_LAST    = 32'(RED_CYC - 1);
  localparam logic [31:0] GREEN_LAST  = 32'(GREEN_CYC - 1);
  localparam logic [31:0] YELLOW_LAST = 32'(YELLOW_CYC - 1);
  localparam logic [31:0] FLASH_LAST  = 32'(FLASH_HALF_CYC - 1);

  typedef enum logic [1:0] {MODE_AUTO, MODE_FLASH, MODE_OFF} mode_t;
  typedef enum logic [1:0] {PH_RED, PH_GREEN, PH_YELLOW} phase_t;

  // Key synchronizers and debouncers; bit 0 = MODE, bit 1 = SKIP.
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       level;
  logic [1:0]       press;
  logic [1:0][31:0] db_cnt;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      sync_a <= '0;
      sync_b <= '0;
      level  <= '0;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      sync_a <= Key;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync_b[i];
          press[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  logic mode_press;
  logic skip_press;

  assign mode_press = press[0];
  assign skip_press = press[1];

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_YELLOW;
      default:  return PH_RED;
    endcase
  endfunction

  function automatic logic [31:0] phase_last(input phase_t p);
    case (p)
      PH_RED:   return RED_LAST;
      PH_GREEN: return GREEN_LAST;
      default:  return YELLOW_LAST;
    endcase
  endfunction

  mode_t       mode;
  phase_t      phase;
  logic [31:0] cnt;
  logic        flash_on;

  // MODE takes priority over SKIP; any mode entry restarts at RED / flash-on.
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      mode     <= MODE_AUTO;
      phase    <= PH_RED;
      cnt      <= '0;
      flash_on <= 1'b0;
    end else if (mode_press) begin
      cnt      <= '0;
      phase    <= PH_RED;
      flash_on <= 1'b1;
      case (mode)
        MODE_AUTO:  mode <= MODE_FLASH;
        MODE_FLASH: mode <= MODE_OFF;
        default:    mode <= MODE_AUTO;
      endcase
    end else begin
      case (mode)
        MODE_AUTO: begin
          if (skip_press || cnt == phase_last(phase)) begin
            phase <= next_phase(phase);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        MODE_FLASH: begin
          if (cnt == FLASH_LAST) begin
            flash_on <= ~flash_on;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  logic [2:0] lamp;

  always_comb begin
    lamp = 3'b000;
    case (mode)
      MODE_AUTO: begin
        case (phase)
          PH_RED:    lamp = 3'b001;
          PH_GREEN:  lamp = 3'b100;
          PH_YELLOW: lamp = 3'b010;
          default:   lamp = 3'b000;
        endcase
      end
      MODE_FLASH: lamp = {1'b0, flash_on, 1'b0};
      default:    lamp = 3'b000;
    endcase
  end

`ifdef HEARTBEAT_EN
  logic [31:0] hb_cnt;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      LED    <= 4'b0000;
      hb_cnt <= '0;
    end else begin
      LED[2:0] <= lamp;
      if (hb_cnt == FLASH_LAST) begin
        hb_cnt <= '0;
        LED[3] <= ~LED[3];
      end else begin
        hb_cnt <= hb_cnt + 32'd1;
      end
    end
  end
`else
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      LED <= 4'b0000;
    end else begin
      LED <= {1'b0, lamp};
    end
  end
`endif

endmodule

// File: tb/tb_main.sv
// Bench for main: directed scenarios plus random key traffic checked every cycle against a behavioural model.
module tb_main;

  localparam int D    = 4;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [3:0] led;

  main #(
    .DEBOUNCE_CYC  (D),
    .RED_CYC       (20),
    .GREEN_CYC     (20),
    .YELLOW_CYC    (8),
    .FLASH_HALF_CYC(HALF)
  ) dut (
    .Sys_CLK(clk),
    .Sys_RST(rst),
    .Key    (key),
    .LED    (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: modes 0=AUTO 1=FLASH 2=OFF; phases 0=RED 1=GREEN 2=YELLOW.
  int         len [3] = '{20, 20, 8};
  int         m_n;
  logic [1:0] m_applied[$];
  logic [1:0] m_samp[$];
  logic [1:0] m_lvl;
  logic [1:0] m_pend;
  int         m_mode;
  int         m_phase;
  int         m_el;
  bit         m_fon;
  logic [3:0] m_exp;

  function automatic logic [2:0] model_lamp();
    if (m_mode == 1) return {1'b0, m_fon, 1'b0};
    if (m_mode == 2) return 3'b000;
    if (m_phase == 0) return 3'b001;
    if (m_phase == 1) return 3'b100;
    return 3'b010;
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_applied.delete();
    m_samp.delete();
    m_lvl   = 2'b00;
    m_pend  = 2'b00;
    m_mode  = 0;
    m_phase = 0;
    m_el    = 0;
    m_fon   = 1'b0;
    m_exp   = 4'b0000;
  endtask

  task automatic model_edge(input logic [1:0] k);
    logic [1:0] s;
    logic [1:0] e;
    bit         all_diff;
    m_exp[2:0] = model_lamp();
    m_n++;
`ifdef HEARTBEAT_EN
    m_exp[3] = ((m_n / HALF) % 2) == 1;
`else
    m_exp[3] = 1'b0;
`endif
    if (m_pend[0]) begin
      m_mode  = (m_mode + 1) % 3;
      m_phase = 0;
      m_el    = 0;
      m_fon   = 1'b1;
    end else if (m_mode == 0) begin
      if (m_pend[1]) begin
        m_phase = (m_phase + 1) % 3;
        m_el    = 0;
      end else begin
        m_el++;
        if (m_el == len[m_phase]) begin
          m_phase = (m_phase + 1) % 3;
          m_el    = 0;
        end
      end
    end else if (m_mode == 1) begin
      m_el++;
      if (m_el == HALF) begin
        m_fon = !m_fon;
        m_el  = 0;
      end
    end
    // A key level reaches the debouncer two edges after it is captured.
    m_applied.push_back(k);
    s = (m_n >= 3) ? m_applied[m_n-3] : 2'b00;
    m_samp.push_back(s);
    m_pend = 2'b00;
    for (int b = 0; b < 2; b++) begin
      all_diff = (m_samp.size() >= D);
      for (int j = 0; j < D && all_diff; j++) begin
        e = m_samp[m_samp.size()-1-j];
        if (e[b] == m_lvl[b]) all_diff = 0;
      end
      if (all_diff) begin
        m_lvl[b]  = s[b];
        m_pend[b] = s[b];
      end
    end
  endtask

  task automatic tick(input logic [1:0] k);
    key = k;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(k);
    #1;
    checks++;
    assert (led === m_exp)
    else begin
      errors++;
      $error("FAIL led n=%0d mode=%0d phase=%0d got=%b exp=%b", m_n, m_mode, m_phase, led, m_exp);
    end
  endtask

  task automatic ticks(input logic [1:0] k, input int n);
    for (int i = 0; i < n; i++) tick(k);
  endtask

  initial begin
    bit found;
    int hold;
    logic [1:0] rk;

    rst = 1'b1;
    key = 2'b00;
    model_reset();

    // Reset held for 5 cycles, then idle through more than two AUTO cycles.
    ticks(2'b00, 5);
    rst = 1'b0;
    ticks(2'b00, 100);

    // Glitch shorter than the debounce window.
    ticks(2'b01, $urandom_range(1, D - 1));
    ticks(2'b00, 30);

    // Three long MODE presses: FLASH, OFF, back to AUTO.
    for (int r = 0; r < 3; r++) begin
      ticks(2'b01, 50);
      ticks(2'b00, 50);
    end

    // SKIP early in RED.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode == 0 && m_phase == 0 && m_el == 0) found = 1;
      else tick(2'b00);
    end
    checks++;
    assert (found)
    else begin
      errors++;
      $error("FAIL wait_red got=%0d exp=1", found);
    end
    ticks(2'b10, 20);
    ticks(2'b00, 40);

    // SKIP while flashing, then back to AUTO.
    ticks(2'b01, 20);
    ticks(2'b00, 12);
    ticks(2'b10, 20);
    ticks(2'b00, 30);
    ticks(2'b01, 20);
    ticks(2'b00, 20);
    ticks(2'b01, 20);
    ticks(2'b00, 30);

    // Both keys together: MODE wins.
    ticks(2'b11, 50);
    ticks(2'b00, 30);
    ticks(2'b01, 20);
    ticks(2'b00, 20);
    ticks(2'b01, 20);
    ticks(2'b00, 10);

    // Asynchronous reset pulse in the middle of GREEN.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode == 0 && m_phase == 1 && m_el == 8) found = 1;
      else tick(2'b00);
    end
    checks++;
    assert (found && led[2:0] === 3'b100)
    else begin
      errors++;
      $error("FAIL wait_green got=%b exp=100", led[2:0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    assert (led === 4'b0000)
    else begin
      errors++;
      $error("FAIL async_rst got=%b exp=0000", led);
    end
    rst = 1'b0;
    model_reset();
    ticks(2'b00, 30);

    // Key held through reset release becomes a fresh press.
    ticks(2'b01, 5);
    rst = 1'b1;
    ticks(2'b01, 3);
    rst = 1'b0;
    ticks(2'b01, 20);
    ticks(2'b00, 20);

    // Random key traffic with holds both shorter and longer than the debounce window.
    for (int s = 0; s < 250; s++) begin
      rk   = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      ticks(rk, hold);
    end
    ticks(2'b00, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
